// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2,
    PC_TRAP   = 2'd3
  } pc_src_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_pc_if.sv
// Control/target bundle between the fetch controller (master) and fetch_pc (slave).
interface fetch_pc_if
  import fetch_pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  stall_i;
  pc_src_e               pc_src_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [PC_WIDTH-1:0]   trap_vec_i;
  logic                  call_i;
  logic                  ret_i;
  logic [PC_WIDTH-1:0]   pc_o;
  logic [PC_WIDTH-1:0]   pc_plus4_o;
  logic                  misalign_o;
  logic                  ras_hit_o;

  modport master (
    output stall_i, pc_src_i, imm_i, rs1_i, trap_vec_i, call_i, ret_i,
    input  pc_o, pc_plus4_o, misalign_o, ras_hit_o
  );

  modport slave (
    input  stall_i, pc_src_i, imm_i, rs1_i, trap_vec_i, call_i, ret_i,
    output pc_o, pc_plus4_o, misalign_o, ras_hit_o
  );

endinterface

// File: rtl/fetch_pc_return_stack.sv
// Circular return-address stack; a full push overwrites the oldest entry.
// Simultaneous push+pop replaces the top in place (coroutine swap).
module return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx_c, wr_idx_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_c, pop_ok_c;

  assign top_idx_c = ptr_q - PTR_W'(1);
  assign top_o     = mem_q[top_idx_c];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok_c  = pop_i && !empty_o;

  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_c  = 1'b0;
    wr_idx_c = ptr_q;
    if (pop_ok_c && push_i) begin
      wr_en_c  = 1'b1;
      wr_idx_c = top_idx_c;
    end else if (pop_ok_c) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_i) begin
      wr_en_c = 1'b1;
      ptr_d   = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries carry no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_idx_c] <= data_i;
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage program counter: seq/branch/jalr/trap selection, stall, misalign trap.
// Optional return-address stack enabled by defining FETCH_PC_RAS_EN.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter int unsigned         DATA_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  fetch_pc_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                misalign_q, misalign_d;
  logic [PC_WIDTH-1:0] pc_plus4_c, imm_c, branch_tgt_c, jalr_sum_c, jalr_tgt_c, tgt_c;
  logic [PC_WIDTH-1:0] ras_top_c;
  logic                redirect_c, misalign_c, pop_cand_c;

  assign imm_c        = bus.imm_i[PC_WIDTH-1:0];
  assign pc_plus4_c   = pc_q + PC_WIDTH'(PC_INC);
  assign branch_tgt_c = pc_q + imm_c;
  assign jalr_sum_c   = bus.rs1_i[PC_WIDTH-1:0] + imm_c;
  assign jalr_tgt_c   = jalr_sum_c & ~PC_WIDTH'(1);

  // Target select, misalign detection and next-state; trap beats stall.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    tgt_c      = pc_plus4_c;
    redirect_c = 1'b0;
    case (bus.pc_src_i)
      PC_BRANCH: begin
        tgt_c      = branch_tgt_c;
        redirect_c = 1'b1;
      end
      PC_JALR: begin
        tgt_c      = pop_cand_c ? ras_top_c : jalr_tgt_c;
        redirect_c = 1'b1;
      end
      default: tgt_c = pc_plus4_c;
    endcase
    misalign_c = redirect_c && tgt_c[1];
    if (bus.pc_src_i == PC_TRAP) begin
      pc_d       = bus.trap_vec_i;
      misalign_d = 1'b0;
    end else if (!bus.stall_i) begin
      pc_d       = misalign_c ? bus.trap_vec_i : tgt_c;
      misalign_d = misalign_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef FETCH_PC_RAS_EN
  logic ras_empty_c, ras_full_c, push_c, pop_c;
  logic unused_ras;

  assign pop_cand_c = bus.ret_i && (bus.pc_src_i == PC_JALR) && !ras_empty_c;
  // Stack only moves on a taken, aligned redirect.
  assign push_c     = bus.call_i && redirect_c && !bus.stall_i && !misalign_c;
  assign pop_c      = pop_cand_c && !bus.stall_i && !misalign_c;
  assign unused_ras = ras_full_c;

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (pc_plus4_c),
    .top_o   (ras_top_c),
    .empty_o (ras_empty_c),
    .full_o  (ras_full_c)
  );
`else
  logic unused_ras;

  assign pop_cand_c = 1'b0;
  assign ras_top_c  = '0;
  assign unused_ras = ^{bus.call_i, bus.ret_i, 32'(RAS_DEPTH)};
`endif

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_plus4_c;
  assign bus.misalign_o = misalign_q;
  assign bus.ras_hit_o  = pop_cand_c;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc (RESET_VECTOR=0x100, RAS_DEPTH=4).
// RAS-specific sequences run only when FETCH_PC_RAS_EN is defined.
module tb_fetch_pc;
  import fetch_pc_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_pc_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  fetch_pc #(
    .PC_WIDTH     (PW),
    .DATA_WIDTH   (DW),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input pc_src_e src, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic call, input logic ret, input logic stall);
    bus.pc_src_i = src;
    bus.imm_i    = imm;
    bus.rs1_i    = rs1;
    bus.call_i   = call;
    bus.ret_i    = ret;
    bus.stall_i  = stall;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trap_to(input logic [31:0] vec);
    bus.trap_vec_i = vec;
    set_in(PC_TRAP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

`ifdef FETCH_PC_RAS_EN
  logic [31:0] ret_exp [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
`endif

  initial begin
    rst = 1'b1;
    bus.trap_vec_i = 32'h0;
    set_in(PC_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_pc", bus.pc_o, 32'h100);
    check("rst_misalign", 32'(bus.misalign_o), 32'h0);
    check("rst_pc_plus4", bus.pc_plus4_o, 32'h104);
    check("rst_ras_hit", 32'(bus.ras_hit_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Sequential fetch from the reset vector
    step(); check("seq1", bus.pc_o, 32'h104);
    step(); check("seq2", bus.pc_o, 32'h108);
    step(); check("seq3", bus.pc_o, 32'h10C);
    check("seq_misalign", 32'(bus.misalign_o), 32'h0);

    trap_to(32'h200);
    check("trap_pc", bus.pc_o, 32'h200);
    set_in(PC_BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0); step();
    check("branch_neg", bus.pc_o, 32'h1F8);
    set_in(PC_JALR, 32'h0, 32'h301, 1'b0, 1'b0, 1'b0); step();
    check("jalr_bit0", bus.pc_o, 32'h300);
    check("jalr_no_misalign", 32'(bus.misalign_o), 32'h0);

    // Misaligned branch traps and pulses misalign_o
    bus.trap_vec_i = 32'h800;
    set_in(PC_BRANCH, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0); step();
    check("mis_branch_pc", bus.pc_o, 32'h800);
    check("mis_branch_flag", 32'(bus.misalign_o), 32'h1);
    set_in(PC_BRANCH, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1); step();
    check("stall_hold_pc", bus.pc_o, 32'h800);
    check("stall_hold_flag", 32'(bus.misalign_o), 32'h1);
    set_in(PC_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); step();
    check("after_mis_pc", bus.pc_o, 32'h804);
    check("after_mis_flag", 32'(bus.misalign_o), 32'h0);

    set_in(PC_BRANCH, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1); step();
    check("stall_branch", bus.pc_o, 32'h804);
    bus.trap_vec_i = 32'h900;
    set_in(PC_TRAP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1); step();
    check("stall_trap", bus.pc_o, 32'h900);

    set_in(PC_JALR, 32'hFFFF_FFFC, 32'h1005, 1'b0, 1'b0, 1'b0); step();
    check("jalr_neg_imm", bus.pc_o, 32'h1000);
    set_in(PC_JALR, 32'h2, 32'h1000, 1'b0, 1'b0, 1'b0); step();
    check("mis_jalr_pc", bus.pc_o, 32'h900);
    check("mis_jalr_flag", 32'(bus.misalign_o), 32'h1);

    // Trap clears misalign; wrap-around at the top of the address space
    trap_to(32'hFFFF_FFFC);
    check("trap_clr_flag", 32'(bus.misalign_o), 32'h0);
    check("wrap_plus4", bus.pc_plus4_o, 32'h0);
    set_in(PC_SEQ, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0); step();
    check("wrap_seq", bus.pc_o, 32'h0);
    set_in(PC_BRANCH, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0); step();
    check("wrap_branch", bus.pc_o, 32'hFFFF_FFFC);

    // Call then return: RAS top when compiled in, else rs1+imm
    trap_to(32'h10);
    set_in(PC_BRANCH, 32'hFF0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check("call_pc", bus.pc_o, 32'h1000);
    set_in(PC_JALR, 32'h4, 32'h2000, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_PC_RAS_EN
    check("ret_hit", 32'(bus.ras_hit_o), 32'h1);
    step(); check("ret_pc", bus.pc_o, 32'h14);
`else
    check("ret_hit", 32'(bus.ras_hit_o), 32'h0);
    step(); check("ret_pc", bus.pc_o, 32'h2004);
`endif

`ifdef FETCH_PC_RAS_EN
    // Five calls into a 4-deep stack: oldest (0x14) is overwritten
    for (int k = 1; k <= 5; k++) begin
      trap_to(32'(k * 16));
      set_in(PC_BRANCH, 32'h1000 - 32'(k * 16), 32'h0, 1'b1, 1'b0, 1'b0); step();
    end
    for (int k = 0; k < 4; k++) begin
      set_in(PC_JALR, 32'h0, 32'h2000, 1'b0, 1'b1, 1'b0);
      check("ras_ret_hit", 32'(bus.ras_hit_o), 32'h1);
      step(); check("ras_ret_pc", bus.pc_o, ret_exp[k]);
    end
    set_in(PC_JALR, 32'h0, 32'h2000, 1'b0, 1'b1, 1'b0);
    check("ras_empty_hit", 32'(bus.ras_hit_o), 32'h0);
    step(); check("ras_empty_pc", bus.pc_o, 32'h2000);

    // Coroutine swap: top 0x80 consumed, replaced by 0x404, depth unchanged
    trap_to(32'h7C);
    set_in(PC_BRANCH, 32'h384, 32'h0, 1'b1, 1'b0, 1'b0); step();
    check("swap_call_pc", bus.pc_o, 32'h400);
    set_in(PC_JALR, 32'h0, 32'h3000, 1'b1, 1'b1, 1'b0);
    check("swap_hit", 32'(bus.ras_hit_o), 32'h1);
    step(); check("swap_pc", bus.pc_o, 32'h80);
    set_in(PC_JALR, 32'h0, 32'h3000, 1'b0, 1'b1, 1'b0);
    check("swap_top_hit", 32'(bus.ras_hit_o), 32'h1);
    step(); check("swap_top_pc", bus.pc_o, 32'h404);
    set_in(PC_JALR, 32'h0, 32'h3000, 1'b0, 1'b1, 1'b0);
    check("swap_cnt_hit", 32'(bus.ras_hit_o), 32'h0);
    step(); check("swap_cnt_pc", bus.pc_o, 32'h3000);
`endif

    // Reset between a push and its pop discards the stack
    trap_to(32'h10);
    set_in(PC_BRANCH, 32'hFF0, 32'h0, 1'b1, 1'b0, 1'b0); step();
    rst = 1'b1;
    #1;
    check("mid_rst_pc", bus.pc_o, 32'h100);
    step();
    rst = 1'b0;
    set_in(PC_JALR, 32'h4, 32'h2000, 1'b0, 1'b1, 1'b0);
    check("post_rst_hit", 32'(bus.ras_hit_o), 32'h0);
    step(); check("post_rst_ret", bus.pc_o, 32'h2004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Parametrised program-counter unit for the single-cycle/fetch stage, successor to the basic PC+4/branch register. It selects the next PC among sequential, PC-relative branch, register-indirect jump and trap-vector targets. It supports pipeline stall, misaligned-target trapping and an optional return-address stack. It drives instruction-memory address and the PC+4 link value to the writeback mux.

## Interface
- PC_WIDTH, 32, width of PC and all targets
- DATA_WIDTH, 32, width of immediate and rs1 operands (≥ PC_WIDTH; low PC_WIDTH bits used)
- RESET_VECTOR, 0, PC value after reset
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold PC and RAS this cycle
- pc_src_i  in  2  0=seq PC+4, 1=branch PC+imm, 2=jalr (rs1+imm)&~1, 3=trap
- imm_i  in  DATA_WIDTH  sign-extended immediate
- rs1_i  in  DATA_WIDTH  jalr base register
- trap_vec_i  in  PC_WIDTH  trap handler address
- call_i  in  1  current redirect is a call (push link)
- ret_i  in  1  current jalr is a return (pop)
- pc_o  out  PC_WIDTH  current PC (registered)
- pc_plus4_o  out  PC_WIDTH  pc_o+4, combinational
- misalign_o  out  1  one-cycle pulse: previous redirect target misaligned
- ras_hit_o  out  1  combinational: current return uses RAS top (0 when RAS compiled out)

## Operation
- Targets, all modulo 2^PC_WIDTH: seq=pc_o+4; branch=pc_o+imm; jalr=(rs1+imm) with bit0 cleared; trap=trap_vec_i.
- Misalign check on branch/jalr target: target[1]≠0 → next PC=trap_vec_i, misalign_o=1 next cycle; RAS not modified.
- Stall: pc_o, RAS and misalign_o hold; pc_src 0/1/2 ignored. pc_src=3 (trap) overrides stall and is taken.
- Trap: never pushes/pops RAS; misalign_o cleared.
- RAS (when compiled in): circular buffer, pointer + count (0..RAS_DEPTH).
  - Push: call_i & pc_src∈{1,2} & taken & aligned → write pc_plus4_o at ptr, ptr+1, count saturates at RAS_DEPTH (full push overwrites oldest).
  - Pop: ret_i & pc_src=2 & count>0 → target = RAS top (ignore rs1+imm), ptr−1, count−1, ras_hit_o=1.
  - Return with count=0 → falls back to jalr target, ras_hit_o=0.
  - call_i & ret_i together on jalr → pop then push (coroutine swap): target=old top, top replaced with pc_plus4_o, count unchanged.
  - call_i/ret_i with pc_src=0 ignored.

## Timing
- Reset: pc_o=RESET_VECTOR, misalign_o=0, RAS count=0, ptr=0; entries unaffected (need no reset).
- Reset mid-operation aborts any push/pop; first rising edge after deassert loads normal next-PC from RESET_VECTOR.
- Redirect latency 1 cycle: inputs sampled at posedge, new pc_o visible after the same edge.
- misalign_o asserted exactly one cycle, coincident with pc_o=trap_vec_i.
- pc_plus4_o and ras_hit_o have zero latency from pc_o/inputs.

## Configuration
- FETCH_PC_RAS_EN defined: RAS storage, push/pop logic and ras_hit_o active as above.
- Undefined: no RAS storage; call_i/ret_i ignored; returns always use (rs1+imm)&~1; ras_hit_o tied 0.

## Structure
- Package fetch_pc_pkg: pc_src_e enum (PC_SEQ, PC_BRANCH, PC_JALR, PC_TRAP), PC_INC constant (4).
- Sub-module return_stack (push/pop/top/empty/full, parametrised depth and width), instantiated only under FETCH_PC_RAS_EN.

## Test plan
- Reset with RESET_VECTOR=0x100, then 3 seq cycles → pc_o 0x100, 0x104, 0x108, 0x10C; misalign_o=0.
- pc_o=0x200, branch imm=−8 → 0x1F8; jalr rs1=0x301 imm=0 → 0x300; branch imm=0x6 from 0x300 → pc_o=trap_vec_i, misalign_o pulse 1 cycle.
- stall_i=1 with branch request → pc_o unchanged; stall_i=1 with trap → pc_o=trap_vec_i next cycle.
- RAS_EN, RAS_DEPTH=4: 5 calls from 0x10,0x20,0x30,0x40,0x50 → 4 returns yield 0x54,0x44,0x34,0x24 with ras_hit_o=1; 5th return uses rs1+imm, ras_hit_o=0.
- call_i&ret_i jalr with top=0x80 from pc 0x400 → pc_o=0x80, top becomes 0x404, count unchanged.
- Assert rst between push and pop → pc_o=RESET_VECTOR, next return falls back to rs1+imm.
